// File: rtl/return_stack.sv
// Return-address stack: push JAL return PCs, pop on function return; top-of-stack read combinationally.
// Latency: push/pop/replace take effect at the next rising edge; ret_addr/sp/empty/full follow state with no extra delay.
// Backpressure: none; push on full and pop on empty are dropped (flagged when RSTACK_GUARD_EN is defined).
module return_stack #(
    parameter int DEPTH = 16,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    output logic [AW-1:0] ret_addr,
    output logic [31:0]   sp,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow,
    input  logic          err_clr
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [AW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_cnt;

    logic          w_empty;
    logic          w_full;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_top_idx;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_do_replace;
    logic          w_ovf_evt;
    logic          w_unf_evt;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(DEPTH));
    // Low bits only: cnt=DEPTH wraps to index 0 here, but that index is never written while full.
    assign w_wr_idx  = r_cnt[IW-1:0];
    // cnt=DEPTH has zero low bits, so subtracting one still lands on DEPTH-1.
    assign w_top_idx = r_cnt[IW-1:0] - IW'(1);

    // A push+pop on an empty stack degenerates into a plain push.
    assign w_do_replace = en & push & pop & ~w_empty;
    assign w_do_push    = en & push & (~pop | w_empty) & ~w_full;
    assign w_do_pop     = en & pop & ~push & ~w_empty;
    // Replace-top on a full stack is legal, so only a lone push can overflow.
    assign w_ovf_evt    = en & push & ~pop & w_full;
    assign w_unf_evt    = en & pop & ~push & w_empty;

    assign ret_addr = w_empty ? '0 : r_mem[w_top_idx];
    assign sp       = {{(32-CW){1'b0}}, r_cnt};
    assign empty    = w_empty;
    assign full     = w_full;

    // Entry count: increments on push, decrements on pop, never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_do_push) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (w_do_pop) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Storage writes: append above the top on push, overwrite the top on replace; pops leave stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[w_wr_idx] <= push_addr;
        end else if (w_do_replace) begin
            r_mem[w_top_idx] <= push_addr;
        end
    end

`ifdef RSTACK_GUARD_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags; a new error at the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_evt) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    // Without the guard the error events and the clear input have no consumer.
    logic w_unused_guard;
    assign w_unused_guard = err_clr ^ w_ovf_evt ^ w_unf_evt;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: directed scenarios plus randomized traffic against a queue model.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
// Guard-flag expectations follow whether RSTACK_GUARD_EN is defined for the build.
module tb_return_stack;

`ifdef RSTACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] push_addr = '0;
    logic [31:0] ret_addr;
    logic [31:0] sp;
    logic        empty, full, overflow, underflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the stack as a queue, the error flags as plain bits.
    logic [31:0] mq[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    return_stack #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk(clk), .reset(reset), .en(en), .push(push), .pop(pop),
        .push_addr(push_addr), .ret_addr(ret_addr), .sp(sp),
        .empty(empty), .full(full), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_top();
        if (mq.size() == 0) return 32'h0;
        return mq[mq.size()-1];
    endfunction

    // Apply one cycle of stimulus and advance the model by the behavioural rules.
    task automatic step(input bit e, input bit pu, input bit po,
                        input logic [31:0] a, input bit c);
        bit ovf_ev, unf_ev;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        @(negedge clk);
        en = e; push = pu; pop = po; push_addr = a; err_clr = c;
        @(posedge clk);
        if (e) begin
            if (pu && po && mq.size() > 0) mq[mq.size()-1] = a;
            else if (pu && mq.size() < DEPTH) mq.push_back(a);
            else if (pu) ovf_ev = 1'b1;
            else if (po && mq.size() > 0) void'(mq.pop_back());
            else if (po) unf_ev = 1'b1;
        end
        if (GUARD) begin
            m_ovf = ovf_ev ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_unf = unf_ev ? 1'b1 : (c ? 1'b0 : m_unf);
        end
        #1;
        en = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++; if (sp !== 32'd0) begin n_err++; $display("FAIL reset_sp got=%0d exp=0", sp); end
        n_vec++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
        n_vec++; if (ret_addr !== 32'h0) begin n_err++; $display("FAIL reset_ret got=%h exp=0", ret_addr); end
        n_vec++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL reset_err got ovf=%b unf=%b exp 0 0", overflow, underflow); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_push_pop();
        step(1, 1, 0, 32'h10, 0);
        step(1, 1, 0, 32'h20, 0);
        step(1, 1, 0, 32'h30, 0);
        n_vec++; if (sp !== 32'd3 || ret_addr !== 32'h30) begin n_err++; $display("FAIL push3 got sp=%0d ret=%h exp sp=3 ret=30", sp, ret_addr); end
        step(1, 0, 1, 32'h0, 0);
        n_vec++; if (sp !== 32'd2 || ret_addr !== 32'h20) begin n_err++; $display("FAIL pop1 got sp=%0d ret=%h exp sp=2 ret=20", sp, ret_addr); end
    endtask

    task automatic test_replace();
        step(1, 1, 1, 32'h99, 0);
        n_vec++; if (sp !== 32'd2 || ret_addr !== 32'h99) begin n_err++; $display("FAIL replace got sp=%0d ret=%h exp sp=2 ret=99", sp, ret_addr); end
        step(1, 0, 1, 32'h0, 0);
        n_vec++; if (sp !== 32'd1 || ret_addr !== 32'h10) begin n_err++; $display("FAIL replace_below got sp=%0d ret=%h exp sp=1 ret=10", sp, ret_addr); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 32'h100 + i, 0);
        step(1, 1, 0, 32'hDEAD, 0);
        n_vec++; if (sp !== 32'd16 || full !== 1'b1) begin n_err++; $display("FAIL full got sp=%0d full=%b exp sp=16 full=1", sp, full); end
        n_vec++; if (ret_addr !== 32'h10F) begin n_err++; $display("FAIL full_ret got=%h exp=10f", ret_addr); end
        n_vec++; if (overflow !== GUARD) begin n_err++; $display("FAIL overflow got=%b exp=%b", overflow, GUARD); end
        step(0, 0, 0, 32'h0, 1);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        step(1, 1, 1, 32'hBEEF, 0);
        n_vec++; if (sp !== 32'd16 || ret_addr !== 32'hBEEF || overflow !== 1'b0) begin n_err++; $display("FAIL full_replace got sp=%0d ret=%h ovf=%b exp 16 beef 0", sp, ret_addr, overflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1, 0, 1, 32'h0, 0);
        n_vec++; if (sp !== 32'd0 || ret_addr !== 32'h0) begin n_err++; $display("FAIL unf_state got sp=%0d ret=%h exp 0 0", sp, ret_addr); end
        n_vec++; if (underflow !== GUARD) begin n_err++; $display("FAIL underflow got=%b exp=%b", underflow, GUARD); end
        step(1, 0, 1, 32'h0, 1);
        n_vec++; if (underflow !== GUARD) begin n_err++; $display("FAIL unf_set_wins got=%b exp=%b", underflow, GUARD); end
        step(0, 0, 0, 32'h0, 1);
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL unf_clr got=%b exp=0", underflow); end
        step(1, 1, 1, 32'h55, 0);
        n_vec++; if (sp !== 32'd1 || ret_addr !== 32'h55 || underflow !== 1'b0) begin n_err++; $display("FAIL pp_empty got sp=%0d ret=%h unf=%b exp 1 55 0", sp, ret_addr, underflow); end
    endtask

    task automatic test_hold_and_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 32'hA0 + i, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 32'hFFFF, 0);
            n_vec++; if (sp !== 32'd4 || ret_addr !== 32'hA3) begin n_err++; $display("FAIL hold%0d got sp=%0d ret=%h exp 4 a3", i, sp, ret_addr); end
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (sp !== 32'd0 || empty !== 1'b1 || clk !== 1'b0) begin n_err++; $display("FAIL async_reset got sp=%0d empty=%b clk=%b exp 0 1 0", sp, empty, clk); end
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        step(1, 1, 0, 32'h77, 0);
        n_vec++; if (sp !== 32'd1 || ret_addr !== 32'h77) begin n_err++; $display("FAIL post_reset got sp=%0d ret=%h exp 1 77", sp, ret_addr); end
    endtask

    task automatic test_random();
        int pu_pct;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            pu_pct = ((i / 100) % 2 == 0) ? 75 : 25;
            step(($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < pu_pct),
                 ($urandom_range(0, 99) < (100 - pu_pct)),
                 $urandom,
                 ($urandom_range(0, 99) < 10));
            n_vec++;
            if (sp !== mq.size() || ret_addr !== m_top() ||
                empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
                overflow !== m_ovf || underflow !== m_unf) begin
                n_err++;
                $display("FAIL rand%0d got sp=%0d ret=%h e=%b f=%b o=%b u=%b exp sp=%0d ret=%h o=%b u=%b",
                         i, sp, ret_addr, empty, full, overflow, underflow,
                         mq.size(), m_top(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_replace();
        test_full();
        test_underflow();
        test_hold_and_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
